alu_result_stage: RTL and testbench

//  Registered downstream stage of the 4-bit combinational ALU. It captures the eight parallel ALU

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_res_fifo.sv | 54 +++++
 rtl/alu_result_stage.sv | 115 +++++++++++
 tb/tb_alu_result_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcodes, flag bit positions and the
// packed FIFO entry layout {op, flags, result}.
package alu_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_MUL  = 3'd2;
    localparam logic [OP_W-1:0] OP_DIV  = 3'd3;
    localparam logic [OP_W-1:0] OP_OR   = 3'd4;
    localparam logic [OP_W-1:0] OP_AND  = 3'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd7;

    localparam int unsigned F_Z = 0;
    localparam int unsigned F_C = 1;
    localparam int unsigned F_V = 2;
    localparam int unsigned F_E = 3;

    // Entry width for a given result width; result sits in the low bits, op on top.
    function automatic int unsigned entry_width(int unsigned w);
        return OP_W + FLAG_W + w;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Generic synchronous FIFO with registered occupancy count; push is ignored when full and
// pop is ignored when empty.
module alu_res_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          wdata,
    output logic [DW-1:0]          rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; stale entries are never visible because empty gates them.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the 4-bit ALU: selects the result by opcode, derives
// {E,V,C,Z} flags, buffers entries in a small FIFO and counts divide-by-zero events.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     ad,
    input  logic [W-1:0]     s,
    input  logic [W-1:0]     m,
    input  logic [W-1:0]     d,
    input  logic [W-1:0]     o,
    input  logic [W-1:0]     an,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     xn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [2:0]       out_op,
    output logic [3:0]       out_flags,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned EW = entry_width(W);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [W-1:0]     sel;
    logic [3:0]       flags;
    logic [W:0]       sum;
    logic [2*W-1:0]   prod;
    logic             b_zero;
    logic             push, pop;
    logic [EW-1:0]    head, shown;
    logic [EW-1:0]    last_q;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [ERR_W-1:0] err_q;

    assign b_zero = (b == '0);
    assign sum    = {1'b0, a} + {1'b0, b};
    assign prod   = (2*W)'(a) * (2*W)'(b);

    always_comb begin
        sel   = '0;
        flags = '0;
        unique case (op)
            OP_ADD:  sel = ad;
            OP_SUB:  sel = s;
            OP_MUL:  sel = m;
            OP_DIV:  sel = b_zero ? '1 : d;  // d is undefined when b is zero
            OP_OR:   sel = o;
            OP_AND:  sel = an;
            OP_XOR:  sel = x;
            OP_XNOR: sel = xn;
            default: sel = '0;
        endcase
        flags[F_Z] = (sel == '0);
        flags[F_C] = ((op == OP_ADD) && sum[W]) || ((op == OP_SUB) && (a < b));
        flags[F_V] = (op == OP_MUL) && (prod[2*W-1:W] != '0);
        flags[F_E] = (op == OP_DIV) && b_zero;
    end

    assign in_ready  = (fifo_count < CW'(DEPTH));
    assign push      = in_valid && !fifo_full;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    alu_res_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({op, flags, sel}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // When the FIFO drains, keep presenting the last entry that was consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '0;
        end else if (pop) begin
            last_q <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (push && flags[F_E] && (err_q != '1)) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign shown      = fifo_empty ? last_q : head;
    assign out_result = shown[W-1:0];
    assign out_flags  = shown[W+3:W];
    assign out_op     = shown[EW-1:W+4];
    assign err_count  = err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed vector table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_alu_result_stage;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] op, out_op;
    logic [3:0] a, b, ad, s, m, d, o, an, x, xn, out_result, out_flags;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] q[$];
    logic [10:0] last_m;
    int          err_m;

    typedef struct {
        int op; int a; int b; int res; int flags;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .ad         (ad),
        .s          (s),
        .m          (m),
        .d          (d),
        .o          (o),
        .an         (an),
        .x          (x),
        .xn         (xn),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_flags  (out_flags),
        .err_count  (err_count)
    );

    // Reference: {op, flags{E,V,C,Z}, result} from plain integer arithmetic.
    function automatic logic [10:0] ref_entry(int t_op, int t_a, int t_b);
        int r;
        logic [3:0] f;
        f = 4'b0000;
        case (t_op)
            0: begin r = t_a + t_b; f[1] = (r > 15); end
            1: begin r = t_a - t_b; f[1] = (t_a < t_b); end
            2: begin r = t_a * t_b; f[2] = (r > 15); end
            3: begin
                if (t_b == 0) begin r = 15; f[3] = 1'b1; end
                else r = t_a / t_b;
            end
            4: r = t_a | t_b;
            5: r = t_a & t_b;
            6: r = t_a ^ t_b;
            default: r = ~(t_a ^ t_b);
        endcase
        r = ((r % 16) + 16) % 16;
        f[0] = (r == 0);
        return {3'(t_op), f, 4'(r)};
    endfunction

    task automatic cmp(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(bit v, int t_op, int t_a, int t_b);
        in_valid = v;
        op = 3'(t_op);
        a  = 4'(t_a);
        b  = 4'(t_b);
        ad = 4'(t_a + t_b);
        s  = 4'(t_a - t_b);
        m  = 4'(t_a * t_b);
        d  = (t_b == 0) ? 4'bxxxx : 4'(t_a / t_b);
        o  = 4'(t_a | t_b);
        an = 4'(t_a & t_b);
        x  = 4'(t_a ^ t_b);
        xn = 4'(~(t_a ^ t_b));
    endtask

    // One clock; the model decides push/pop from pre-edge inputs, then updates after the edge.
    task automatic step();
        bit acc, pp, in_rst;
        logic [10:0] e;
        in_rst = rst;
        acc = in_valid && (q.size() < DEPTH);
        pp  = out_ready && (q.size() > 0);
        e   = ref_entry(int'(op), int'(a), int'(b));
        @(posedge clk);
        #1;
        if (in_rst) begin
            q.delete();
            err_m  = 0;
            last_m = '0;
        end else begin
            if (pp) begin
                last_m = q[0];
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(e);
                if (e[7] && err_m < 255) err_m++;
            end
        end
    endtask

    task automatic check(string tag);
        logic [10:0] exp;
        exp = (q.size() > 0) ? q[0] : last_m;
        cmp({tag, " out_valid"}, int'(out_valid), int'(q.size() > 0));
        cmp({tag, " in_ready"}, int'(in_ready), int'(q.size() < DEPTH));
        cmp({tag, " out_result"}, int'(out_result), int'(exp[3:0]));
        cmp({tag, " out_flags"}, int'(out_flags), int'(exp[7:4]));
        cmp({tag, " out_op"}, int'(out_op), int'(exp[10:8]));
        cmp({tag, " err_count"}, int'(err_count), err_m);
    endtask

    initial begin
        vecs.push_back('{0, 10, 1, 11, 4'b0000});
        vecs.push_back('{0,  9, 8,  1, 4'b0010});
        vecs.push_back('{1,  3, 5, 14, 4'b0010});
        vecs.push_back('{2,  5, 4,  4, 4'b0100});
        vecs.push_back('{3, 10, 0, 15, 4'b1000});
        vecs.push_back('{1,  5, 5,  0, 4'b0001});
        vecs.push_back('{7,  5, 10, 0, 4'b0001});
        vecs.push_back('{4, 12, 3, 15, 4'b0000});
        vecs.push_back('{5, 12, 10, 8, 4'b0000});
        vecs.push_back('{6,  6, 6,  0, 4'b0001});
        vecs.push_back('{0, 15, 1,  0, 4'b0011});
        vecs.push_back('{2,  3, 5, 15, 4'b0000});
        vecs.push_back('{3, 15, 4,  3, 4'b0000});
        vecs.push_back('{3,  0, 0, 15, 4'b1000});

        q.delete();
        last_m = '0;
        err_m  = 0;
        rst = 1'b1;
        out_ready = 1'b0;
        drive(0, 0, 0, 0);
        step();
        rst = 1'b0;
        check("reset");

        // Directed vectors: push one, check it one cycle later, then let it drain.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(1, vecs[i].op, vecs[i].a, vecs[i].b);
            step();
            check("vec");
            cmp("vec result", int'(out_result), vecs[i].res);
            cmp("vec flags", int'(out_flags), vecs[i].flags);
            drive(0, 0, 0, 0);
            step();
            check("vec drain");
        end

        // Saturation of the divide-by-zero counter.
        drive(1, 3, 10, 0);
        for (int i = 0; i < 256; i++) step();
        cmp("err saturated", int'(err_count), 255);
        drive(0, 0, 0, 0);
        step();
        step();
        check("err hold");

        // Fill to full with the consumer stalled; third push must be refused.
        out_ready = 1'b0;
        drive(1, 6, 1, 2);
        step();
        drive(1, 6, 3, 4);
        step();
        cmp("full in_ready", int'(in_ready), 0);
        drive(1, 6, 5, 6);
        step();
        check("full hold");
        cmp("full head", int'(out_result), 3);
        drive(0, 0, 0, 0);
        out_ready = 1'b1;
        step();
        cmp("after pop in_ready", int'(in_ready), 1);
        cmp("second head", int'(out_result), 7);
        check("drain1");
        step();
        check("drain2");
        cmp("empty valid", int'(out_valid), 0);

        // Simultaneous push and pop at count 1.
        out_ready = 1'b0;
        drive(1, 0, 2, 3);
        step();
        out_ready = 1'b1;
        drive(1, 5, 12, 10);
        step();
        cmp("pushpop valid", int'(out_valid), 1);
        cmp("pushpop in_ready", int'(in_ready), 1);
        cmp("pushpop head", int'(out_result), 8);
        check("pushpop");
        drive(0, 0, 0, 0);
        step();

        // Reset with two entries buffered.
        out_ready = 1'b0;
        drive(1, 6, 9, 3);
        step();
        step();
        drive(0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp("rst valid", int'(out_valid), 0);
        cmp("rst in_ready", int'(in_ready), 1);
        cmp("rst err", int'(err_count), 0);
        cmp("rst result", int'(out_result), 0);
        cmp("rst op", int'(out_op), 0);
        cmp("rst flags", int'(out_flags), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            out_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 60) == 0);
            step();
            rst = 1'b0;
            check("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
